pipeline_ctrl: RTL and testbench

//  Hazard/stall controller that drives the enable, freeze and flush inputs of the four pipeline latches (f_d, d_ex, ex_m, m_wb) and the PC.

---
 rtl/pipeline_ctrl_pkg.sv | 5 +
 rtl/pipeline_ctrl_if.sv | 15 +
 rtl/pipeline_ctrl_sat_counter.sv | 11 +
 rtl/pipeline_ctrl.sv | 42 ++++
 tb/tb_pipeline_ctrl.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding and register constants for the pipeline controller
package cpu_types_pkg;
  typedef enum logic [1:0] {PC_RUN, PC_MEMWAIT, PC_HALTED} pctrl_state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs from the datapath and latch controls back to it
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
  logic ihit, dhit, fd_uses_rt, dex_dREN, ex_redirect, exm_dREN, exm_dWEN, mwb_halt;
  logic [4:0] fd_rs, fd_rt, dex_rt;
  logic pc_en, fd_en, fd_flush, dex_freeze, dex_flush, exm_en, mwb_en, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output ihit, dhit, fd_rs, fd_rt, fd_uses_rt, dex_dREN, dex_rt, ex_redirect, exm_dREN, exm_dWEN, mwb_halt,
    input pc_en, fd_en, fd_flush, dex_freeze, dex_flush, exm_en, mwb_en, halted, stall_cnt, flush_cnt
  );
  modport slave (
    input ihit, dhit, fd_rs, fd_rt, fd_uses_rt, dex_dREN, dex_rt, ex_redirect, exm_dREN, exm_dWEN, mwb_halt,
    output pc_en, fd_en, fd_flush, dex_freeze, dex_flush, exm_en, mwb_en, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: counter that sticks at all-ones instead of wrapping
module sat_counter #(parameter int W = 32) (
  input  logic         clk,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: load-use / redirect / memory-wait / halt controller for the pipeline latches and PC
module pipeline_ctrl
  import cpu_types_pkg::*;
#(parameter int CNT_W = 32) (
  input logic           clk,
  input logic           nRST,
  pipeline_ctrl_if.slave bus
);
  pctrl_state_t state;
  logic mem_busy, stall_mem, lu_haz, halt_now, stop, redir, frz;
  always_comb begin
    mem_busy  = (bus.exm_dREN | bus.exm_dWEN) & ~bus.dhit;
    stall_mem = (state == PC_MEMWAIT) ? ~bus.dhit : mem_busy;
    lu_haz    = bus.dex_dREN && bus.dex_rt != REG_ZERO &&
                (bus.dex_rt == bus.fd_rs || (bus.fd_uses_rt && bus.dex_rt == bus.fd_rt));
    halt_now  = state == PC_HALTED || bus.mwb_halt;
    // while in reset every input is ignored so the latches run freely
    stop      = nRST & (halt_now | stall_mem);
    redir     = nRST & ~stop & bus.ex_redirect;
    frz       = nRST & ~stop & ~bus.ex_redirect & lu_haz;
    bus.pc_en      = ~stop & ~frz;
    bus.fd_en      = ~stop & ~frz;
    bus.fd_flush   = redir;
    bus.dex_flush  = redir;
    bus.dex_freeze = frz;
    bus.exm_en     = ~stop;
    bus.mwb_en     = ~stop;
    bus.halted     = state == PC_HALTED;
  end
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) state <= PC_RUN;
    else if (bus.mwb_halt) state <= PC_HALTED;
    else state <= (state == PC_HALTED)  ? PC_HALTED :
                  (state == PC_MEMWAIT) ? (bus.dhit ? PC_RUN : PC_MEMWAIT) :
                  (mem_busy ? PC_MEMWAIT : PC_RUN);
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .nRST(nRST), .inc(~bus.pc_en & (state != PC_HALTED)), .cnt(bus.stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush (
    .clk(clk), .nRST(nRST), .inc(bus.ex_redirect & bus.ihit & ~halt_now), .cnt(bus.flush_cnt)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors against a behavioural model of the pipeline controller
module tb_pipeline_ctrl;
  localparam int W = 4;
  localparam int SAT = (1 << W) - 1;
  logic clk = 0;
  logic nRST = 1;
  always #5 clk = ~clk;
  pipeline_ctrl_if #(.CNT_W(W)) bus ();
  pipeline_ctrl #(.CNT_W(W)) dut (.clk(clk), .nRST(nRST), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  bit m_halt, m_wait;
  int m_stall, m_flush;
  logic [6:0] e_up;
  // {pc_en, fd_en, fd_flush, dex_freeze, dex_flush, exm_en, mwb_en}
  function automatic logic [6:0] exp_ctrl();
    bit blocked, lu;
    if (!nRST) return 7'b1100011;
    blocked = m_halt || bus.mwb_halt ||
              (m_wait ? !bus.dhit : ((bus.exm_dREN || bus.exm_dWEN) && !bus.dhit));
    lu = bus.dex_dREN && bus.dex_rt != 0 &&
         (bus.dex_rt == bus.fd_rs || (bus.fd_uses_rt && bus.dex_rt == bus.fd_rt));
    if (blocked) return 7'b0000000;
    if (bus.ex_redirect) return 7'b1110111;
    if (lu) return 7'b0001011;
    return 7'b1100011;
  endfunction
  always @(posedge clk or negedge nRST)
    if (!nRST) begin
      m_halt = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      e_up = exp_ctrl();
      if (!e_up[6] && !m_halt && m_stall < SAT) m_stall++;
      if (bus.ex_redirect && bus.ihit && !m_halt && !bus.mwb_halt && m_flush < SAT) m_flush++;
      if (bus.mwb_halt) m_halt = 1;
      else if (!m_halt) m_wait = m_wait ? !bus.dhit : ((bus.exm_dREN || bus.exm_dWEN) && !bus.dhit);
    end
  always @(negedge clk) begin
    chk("ctrl", {bus.pc_en, bus.fd_en, bus.fd_flush, bus.dex_freeze, bus.dex_flush, bus.exm_en, bus.mwb_en},
        exp_ctrl());
    chk("halted", bus.halted, m_halt);
    chk("stall_cnt", bus.stall_cnt, m_stall);
    chk("flush_cnt", bus.flush_cnt, m_flush);
  end
  task automatic clr();
    bus.ihit = 1; bus.dhit = 0; bus.fd_rs = 0; bus.fd_rt = 0; bus.fd_uses_rt = 0;
    bus.dex_dREN = 0; bus.dex_rt = 0; bus.ex_redirect = 0; bus.exm_dREN = 0; bus.exm_dWEN = 0;
    bus.mwb_halt = 0;
  endtask
  task automatic lu_set();
    bus.dex_dREN = 1; bus.dex_rt = 8; bus.fd_rs = 8;
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  initial begin
    clr();
    lu_set();
    bus.mwb_halt = 1;
    #1 nRST = 0;
    @(negedge clk);
    chk("rst_pc_en", bus.pc_en, 1);
    chk("rst_freeze", bus.dex_freeze, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_stall", bus.stall_cnt, 0);
    nxt(); clr(); nRST = 1;
    nxt(); lu_set();
    @(negedge clk);
    chk("lu_pc_en", bus.pc_en, 0);
    chk("lu_fd_en", bus.fd_en, 0);
    chk("lu_freeze", bus.dex_freeze, 1);
    nxt(); clr();
    @(negedge clk);
    chk("lu_release_pc_en", bus.pc_en, 1);
    chk("lu_stall_cnt", bus.stall_cnt, 1);
    nxt(); bus.dex_dREN = 1;
    @(negedge clk);
    chk("r0_no_stall", bus.pc_en, 1);
    nxt(); bus.dex_rt = 5; bus.fd_rt = 5; bus.fd_rs = 1;
    @(negedge clk);
    chk("rt_unused_no_stall", bus.pc_en, 1);
    nxt(); bus.fd_uses_rt = 1;
    @(negedge clk);
    chk("rt_used_stall", bus.pc_en, 0);
    nxt(); clr(); bus.ex_redirect = 1; lu_set();
    @(negedge clk);
    chk("redir_fd_flush", bus.fd_flush, 1);
    chk("redir_dex_flush", bus.dex_flush, 1);
    chk("redir_freeze", bus.dex_freeze, 0);
    chk("redir_pc_en", bus.pc_en, 1);
    nxt(); clr();
    @(negedge clk);
    chk("redir_flush_cnt", bus.flush_cnt, 1);
    chk("redir_stall_cnt", bus.stall_cnt, 2);
    nxt(); bus.exm_dREN = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_pc_en", bus.pc_en, 0);
      chk("mw_exm_en", bus.exm_en, 0);
      nxt();
    end
    bus.dhit = 1;
    @(negedge clk);
    chk("mw_dhit_pc_en", bus.pc_en, 1);
    chk("mw_dhit_mwb_en", bus.mwb_en, 1);
    chk("mw_stall_cnt", bus.stall_cnt, 5);
    nxt(); clr();
    @(negedge clk);
    chk("mw_back_run", bus.pc_en, 1);
    nxt(); bus.mwb_halt = 1; bus.ex_redirect = 1;
    @(negedge clk);
    chk("halt_no_flush", bus.fd_flush, 0);
    chk("halt_not_yet", bus.halted, 0);
    nxt(); clr();
    @(negedge clk);
    chk("halted", bus.halted, 1);
    chk("halted_pc_en", bus.pc_en, 0);
    chk("halted_flush_cnt", bus.flush_cnt, 1);
    nxt();
    @(negedge clk);
    chk("halted_sticky", bus.halted, 1);
    nxt(); nRST = 0;
    @(negedge clk);
    chk("rst2_halted", bus.halted, 0);
    chk("rst2_stall", bus.stall_cnt, 0);
    chk("rst2_flush", bus.flush_cnt, 0);
    nxt(); nRST = 1; lu_set();
    repeat (20) nxt();
    @(negedge clk);
    chk("sat_stall", bus.stall_cnt, SAT);
    nxt();
    @(negedge clk);
    chk("sat_hold", bus.stall_cnt, SAT);
    nxt(); clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
